// File: rtl/cnt_ctrl_pkg.sv
// Shared types and default sizes for the counter sequencer.
package cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH   = 2;
    localparam int unsigned DEF_ROUND_W = 4;

endpackage

// File: rtl/cnt_ctrl_core.sv
// Counter register with clear, enable and a terminal-count compare; it wraps to 0 when it is enabled at terminal count.
module cnt_core #(
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_limit);

endmodule

// File: rtl/cnt_ctrl.sv
// Start/pause/stop sequencer running 0..limit for a latched number of rounds, with registered busy and a one-cycle done pulse.
// CNT_CTRL_AUTORELOAD_EN: when it is defined, DONE re-enters RUN with the same latched parameters instead of returning to IDLE.
module cnt_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ROUND_W = DEF_ROUND_W
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic               w_start,
    input  logic               w_stop,
    input  logic               w_pause,
    input  logic [WIDTH-1:0]   w_limit,
    input  logic [ROUND_W-1:0] w_rounds,
    output logic [WIDTH-1:0]   w_cnt,
    output logic               w_busy,
    output logic               w_done
);

    state_t             r_state;
    state_t             w_nxt;
    logic [WIDTH-1:0]   r_limit;
    logic [ROUND_W-1:0] r_rounds;
    logic [ROUND_W-1:0] r_round;
    logic               r_busy;
    logic               r_done;
    logic               w_tc;
    logic               w_last;
    logic               w_en;
    logic               w_clr;
    logic               w_busy_d;
    logic               w_done_d;

    assign w_last = (r_round == r_rounds - ROUND_W'(1));

    cnt_core #(.WIDTH(WIDTH)) u_core (
        .i_clk   (w_clk),
        .i_rst   (w_rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_limit (r_limit),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_nxt = ST_RUN;
            ST_RUN: begin
                if (w_stop)               w_nxt = ST_IDLE;
                else if (w_pause)         w_nxt = ST_HOLD;
                else if (w_tc && w_last)  w_nxt = ST_DONE;
            end
            ST_HOLD: begin
                if (w_stop)        w_nxt = ST_IDLE;
                else if (!w_pause) w_nxt = ST_RUN;
            end
`ifdef CNT_CTRL_AUTORELOAD_EN
            ST_DONE: w_nxt = ST_RUN;
`else
            ST_DONE: w_nxt = ST_IDLE;
`endif
            default: w_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        w_busy_d = (w_nxt == ST_RUN) || (w_nxt == ST_HOLD);
        w_done_d = (w_nxt == ST_DONE);
        w_en     = (r_state == ST_RUN) && !w_stop && !w_pause;
        w_clr    = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                   (((r_state == ST_RUN) || (r_state == ST_HOLD)) && w_stop);
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_limit  <= '0;
            r_rounds <= ROUND_W'(1);
            r_round  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_start) begin
                r_limit  <= w_limit;
                r_rounds <= (w_rounds == '0) ? ROUND_W'(1) : w_rounds;
            end
            if (w_clr) begin
                r_round <= '0;
            end else if (w_en && w_tc) begin
                r_round <= w_last ? '0 : r_round + ROUND_W'(1);
            end
        end
    end

    assign w_busy = r_busy;
    assign w_done = r_done;

endmodule
